pwm_carrier_sel_sched: RTL and testbench



---
 rtl/pwm_carrier_sel_sched_pkg.sv | 16 +
 rtl/pwm_carrier_sel_sched_if.sv | 32 +++
 rtl/pwm_sel_ch_slot.sv | 108 ++++++++++
 rtl/pwm_carrier_sel_sched.sv | 57 +++++
 tb/tb_pwm_carrier_sel_sched.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_carrier_sel_sched_pkg.sv
// Shared PWM definitions used by the carrier-selection scheduler.
//   NUM_CARR    : number of free-running carriers in the PWM core
//   CARR_SEL_W  : width of a carrier index
//   carr_sel_t  : carrier index type
//   sel_state_t : per-channel scheduler state
package PKG_pwm;
    localparam int NUM_CARR   = 8;
    localparam int CARR_SEL_W = 3;

    typedef logic [CARR_SEL_W-1:0] carr_sel_t;

    typedef enum logic {
        SEL_IDLE,
        SEL_PEND
    } sel_state_t;
endpackage

// File: rtl/pwm_carrier_sel_sched_if.sv
// Selection-change request port of the carrier-selection scheduler.
//   cfg_valid : request present
//   cfg_ready : request accepted when high together with cfg_valid
//   cfg_ch    : target channel
//   cfg_sel   : new carrier index for cfg_ch
//   cfg_force : apply immediately instead of waiting for the carrier zero
// master = requester (software side), slave = scheduler.
interface pwm_carrier_sel_sched_if
    import PKG_pwm::*;
;
    logic      cfg_valid;
    logic      cfg_ready;
    logic [2:0] cfg_ch;
    carr_sel_t cfg_sel;
    logic      cfg_force;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_sel,
        output cfg_force,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_sel,
        input  cfg_force,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_sel_ch_slot.sv
// One channel of the carrier-selection scheduler: holds the live carrier
// select, the shadow (pending) select, the watchdog counter and the sticky
// watchdog flag.
//   clk, rst    : clock, synchronous active-high reset
//   accept      : a request for this channel is accepted this cycle
//   req_sel     : requested carrier index
//   req_force   : apply the request at the next edge
//   carr_zero   : per-carrier wrap pulses
//   tmo_cycles  : watchdog limit, 0 disables
//   tmo_clr     : clear the sticky watchdog flag
//   sel         : registered carrier select for this channel
//   pend        : an update is waiting for its carrier zero
//   upd_pulse   : first cycle a new sel value is visible
//   tmo_flag    : last update was forced by the watchdog
module pwm_sel_ch_slot
    import PKG_pwm::*;
#(
    parameter int TMO_W   = 16,
    parameter int RST_SEL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  carr_sel_t           req_sel,
    input  logic                req_force,
    input  logic [NUM_CARR-1:0] carr_zero,
    input  logic [TMO_W-1:0]    tmo_cycles,
    input  logic                tmo_clr,
    output carr_sel_t           sel,
    output logic                pend,
    output logic                upd_pulse,
    output logic                tmo_flag
);
    sel_state_t       state_reg, state_next;
    carr_sel_t        sel_reg, sel_next;
    carr_sel_t        shadow_reg, shadow_next;
    logic [TMO_W-1:0] cnt_reg, cnt_next;
    logic             upd_reg, upd_next;
    logic             flag_reg, flag_next;
    logic             expired;

    assign expired = (tmo_cycles != '0) && (cnt_reg == tmo_cycles - TMO_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= SEL_IDLE;
            sel_reg    <= carr_sel_t'(RST_SEL);
            shadow_reg <= '0;
            cnt_reg    <= '0;
            upd_reg    <= 1'b0;
            flag_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
            upd_reg    <= upd_next;
            flag_reg   <= flag_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        upd_next    = 1'b0;
        // Clear first so that a watchdog set below in the same cycle wins.
        flag_next   = tmo_clr ? 1'b0 : flag_reg;

        case (state_reg)
            SEL_IDLE: begin
                if (accept) begin
                    if (req_force) begin
                        sel_next = req_sel;
                        upd_next = 1'b1;
                    end else if (req_sel != sel_reg) begin
                        shadow_next = req_sel;
                        cnt_next    = '0;
                        state_next  = SEL_PEND;
                    end
                    // Same carrier without force: nothing to do.
                end
            end
            SEL_PEND: begin
                // Zero event takes priority over a simultaneous watchdog expiry.
                if (carr_zero[shadow_reg]) begin
                    sel_next   = shadow_reg;
                    upd_next   = 1'b1;
                    state_next = SEL_IDLE;
                end else if (expired) begin
                    sel_next   = shadow_reg;
                    upd_next   = 1'b1;
                    flag_next  = 1'b1;
                    state_next = SEL_IDLE;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + TMO_W'(1);
                end
            end
            default: state_next = SEL_IDLE;
        endcase
    end

    assign sel       = sel_reg;
    assign pend      = (state_reg == SEL_PEND);
    assign upd_pulse = upd_reg;
    assign tmo_flag  = flag_reg;
endmodule

// File: rtl/pwm_carrier_sel_sched.sv
// Carrier-selection scheduler for the PWM channels. Each channel's carrier
// select is changed only at the next zero of the newly chosen carrier (or
// at once when forced, or by a per-channel watchdog).
//   clk, rst    : clock, synchronous active-high reset
//   carr_zero   : per-carrier wrap pulses
//   cfg         : selection-change request port (slave side)
//   tmo_cycles  : watchdog limit in cycles, 0 disables
//   tmo_clr     : per-channel clear of tmo_flag
//   sel_out     : per-channel carrier select, channel ch at [3*ch +: 3]
//   pend        : per-channel update pending
//   upd_pulse   : per-channel one-cycle pulse when a new select is visible
//   tmo_flag    : per-channel sticky watchdog-forced flag
module pwm_carrier_sel_sched
    import PKG_pwm::*;
#(
    parameter int NUM_CH = 8,
    parameter int TMO_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CARR-1:0]        carr_zero,
    pwm_carrier_sel_sched_if.slave     cfg,
    input  logic [TMO_W-1:0]           tmo_cycles,
    input  logic [NUM_CH-1:0]          tmo_clr,
    output logic [NUM_CH*CARR_SEL_W-1:0] sel_out,
    output logic [NUM_CH-1:0]          pend,
    output logic [NUM_CH-1:0]          upd_pulse,
    output logic [NUM_CH-1:0]          tmo_flag
);
    logic accept;

    // A pending request is never overwritten: the requester waits.
    assign cfg.cfg_ready = !rst && !pend[cfg.cfg_ch];
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_sel_ch_slot #(
                .TMO_W   (TMO_W),
                .RST_SEL (gi)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .accept     (accept && (cfg.cfg_ch == 3'(gi))),
                .req_sel    (cfg.cfg_sel),
                .req_force  (cfg.cfg_force),
                .carr_zero  (carr_zero),
                .tmo_cycles (tmo_cycles),
                .tmo_clr    (tmo_clr[gi]),
                .sel        (sel_out[CARR_SEL_W*gi +: CARR_SEL_W]),
                .pend       (pend[gi]),
                .upd_pulse  (upd_pulse[gi]),
                .tmo_flag   (tmo_flag[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_pwm_carrier_sel_sched.sv
// Directed bench for pwm_carrier_sel_sched with an update scoreboard.
module tb_pwm_carrier_sel_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  carr_zero = '0;
    logic [15:0] tmo_cycles = '0;
    logic [7:0]  tmo_clr = '0;
    logic [23:0] sel_out;
    logic [7:0]  pend, upd_pulse, tmo_flag;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          mon_idx;
    int          a;

    localparam logic [23:0] SEL_DEFAULT = 24'hFAC688;

    typedef struct {
        int ch;
        int sel;
        int flag;
        int cyc;
    } exp_t;
    exp_t sb[$];

    pwm_carrier_sel_sched_if cfg_if ();

    pwm_carrier_sel_sched #(.NUM_CH(8), .TMO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .carr_zero  (carr_zero),
        .cfg        (cfg_if.slave),
        .tmo_cycles (tmo_cycles),
        .tmo_clr    (tmo_clr),
        .sel_out    (sel_out),
        .pend       (pend),
        .upd_pulse  (upd_pulse),
        .tmo_flag   (tmo_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input int sel, input int flag, input int at);
        exp_t e;
        e.ch = ch; e.sel = sel; e.flag = flag; e.cyc = at;
        sb.push_back(e);
    endtask

    // Issue one request that must be accepted; acc returns the cycle index
    // right after the acceptance edge.
    task automatic do_req(input int ch, input int sel, input int frc, output int acc);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_sel   = 3'(sel);
        cfg_if.cfg_force = frc[0];
        #1;
        check($sformatf("ready_ch%0d", ch), int'(cfg_if.cfg_ready), 1);
        acc = cyc + 1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_force = 1'b0;
    endtask

    task automatic zero(input logic [7:0] mask);
        carr_zero = mask;
        tick();
        carr_zero = '0;
    endtask

    // Monitor: every upd_pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < 8; ch++) begin
                if (upd_pulse[ch]) begin
                    mon_idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (mon_idx < 0 && sb[i].ch == ch) mon_idx = i;
                    if (mon_idx < 0) begin
                        check($sformatf("unexpected_upd_ch%0d", ch), 1, 0);
                    end else begin
                        check($sformatf("upd_sel_ch%0d", ch), int'(sel_out[3*ch +: 3]), sb[mon_idx].sel);
                        check($sformatf("upd_flag_ch%0d", ch), int'(tmo_flag[ch]), sb[mon_idx].flag);
                        check($sformatf("upd_cycle_ch%0d", ch), cyc, sb[mon_idx].cyc);
                        check($sformatf("upd_pend_low_ch%0d", ch), int'(pend[ch]), 0);
                        sb.delete(mon_idx);
                    end
                end
            end
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_sel   = '0;
        cfg_if.cfg_force = 1'b0;

        // Reset state
        repeat (3) tick();
        cfg_if.cfg_valid = 1'b1;
        #1;
        check("rst_sel_out", int'(sel_out), int'(SEL_DEFAULT));
        check("rst_pend", int'(pend), 0);
        check("rst_tmo_flag", int'(tmo_flag), 0);
        check("rst_ready", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Channel 2 -> carrier 5, zero of carrier 5 ten cycles later
        do_req(2, 5, 0, a);
        check("t1_pend2", int'(pend[2]), 1);
        repeat (10) tick();
        push_exp(2, 5, 0, cyc + 1);
        zero(8'h20);
        check("t1_pend2_low", int'(pend[2]), 0);

        // Channel 1 -> 5: zero in acceptance cycle and a wrong carrier are ignored
        carr_zero = 8'h20;
        do_req(1, 5, 0, a);
        carr_zero = '0;
        tick();
        zero(8'h08);
        repeat (3) tick();
        check("t2_pend1", int'(pend[1]), 1);
        check("t2_sel1_unchanged", int'(sel_out[5:3]), 1);
        push_exp(1, 5, 0, cyc + 1);
        zero(8'h20);

        // Busy channel blocks, other channel accepted, both complete together
        do_req(2, 6, 0, a);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd2;
        cfg_if.cfg_sel   = 3'd1;
        #1;
        check("t3_ready_busy", int'(cfg_if.cfg_ready), 0);
        tick();
        cfg_if.cfg_valid = 1'b0;
        do_req(4, 0, 0, a);
        check("t3_pend_2_4", int'(pend), 8'h14);
        push_exp(2, 6, 0, cyc + 1);
        push_exp(4, 0, 0, cyc + 1);
        zero(8'h41);

        // Watchdog: tmo_cycles = 4
        tmo_cycles = 16'd4;
        do_req(3, 7, 0, a);
        push_exp(3, 7, 1, a + 4);
        repeat (5) tick();
        check("t4_flag_set", int'(tmo_flag[3]), 1);
        tmo_clr = 8'h08;
        tick();
        tmo_clr = '0;
        check("t4_flag_clr", int'(tmo_flag[3]), 0);
        do_req(3, 2, 0, a);
        push_exp(3, 2, 1, a + 4);
        repeat (3) tick();
        tmo_clr = 8'h08;
        tick();
        tmo_clr = '0;
        tick();
        check("t4_set_beats_clr", int'(tmo_flag[3]), 1);

        // Zero and expiry together: zero wins, no flag
        do_req(5, 1, 0, a);
        push_exp(5, 1, 0, a + 4);
        repeat (3) tick();
        zero(8'h02);
        tick();
        check("t4_tie_flag5", int'(tmo_flag[5]), 0);

        // Force path and same-carrier drop
        push_exp(6, 0, 0, cyc + 1);
        do_req(6, 0, 1, a);
        check("t5_force_pend6", int'(pend[6]), 0);
        do_req(7, 7, 0, a);
        check("t5_same_pend7", int'(pend[7]), 0);
        repeat (3) tick();

        // Reset while two channels are pending
        tmo_cycles = '0;
        do_req(0, 4, 0, a);
        do_req(1, 2, 0, a);
        check("t6_pend_0_1", int'(pend), 8'h03);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("t6_sel_default", int'(sel_out), int'(SEL_DEFAULT));
        check("t6_pend_clear", int'(pend), 0);
        check("t6_flag_clear", int'(tmo_flag), 0);
        zero(8'h14);
        repeat (3) tick();
        check("t6_sel_still_default", int'(sel_out), int'(SEL_DEFAULT));
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
